bus_slave_regfile: RTL and testbench

//  Generic bus slave responder: answers the shared slave-side bus (s_cs_, s_as_, s_rw, s_addr,
//  s_wr_data) with s_rdy_ / s_rd_data after a programmable number of wait states.

---
 rtl/bus_slave_regfile_pkg.sv | 20 ++
 rtl/bus_slave_ctrl.sv | 80 ++++++++
 rtl/bus_slave_regfile.sv | 90 +++++++++
 tb/tb_bus_slave_regfile.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_regfile_pkg.sv
// Shared slave-bus definitions: bus widths, active-low strobe levels,
// transfer direction and slave responder FSM state encodings.
package bus_slave_regfile_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned WORD_DATA_W = 32;
    localparam int unsigned WAIT_CNT_W  = 4;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic [1:0] {
        BUS_SLV_IDLE = 2'd0,
        BUS_SLV_WAIT = 2'd1,
        BUS_SLV_ACK  = 2'd2
    } bus_slv_state_e;

endpackage

// File: rtl/bus_slave_ctrl.sv
// Slave handshake sequencer: IDLE/WAIT/ACK with a wait-state counter.
// Emits the registered ready strobe plus combinational latch/commit strobes.
module bus_slave_ctrl
    import bus_slave_regfile_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_,
    input  logic req_c,
    input  logic rw,
    output logic rdy_,
    output logic latch_c,
    output logic rd_ack_c,
    output logic wr_commit_c
);

    bus_slv_state_e          state, state_nxt;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_nxt;
    logic                    rw_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= BUS_SLV_IDLE;
            cnt   <= '0;
            rw_q  <= READ;
            rdy_  <= DISABLE_;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_c) begin
                rw_q <= rw;
            end
            // Ready lags the ACK state by one register stage.
            rdy_  <= (state == BUS_SLV_ACK) ? ENABLE_ : DISABLE_;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        latch_c     = 1'b0;
        rd_ack_c    = 1'b0;
        wr_commit_c = 1'b0;
        case (state)
            BUS_SLV_IDLE: begin
                if (req_c) begin
                    latch_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = BUS_SLV_ACK;
                    end else begin
                        cnt_nxt   = WAIT_CNT_W'(WAIT_CYCLES);
                        state_nxt = BUS_SLV_WAIT;
                    end
                end
            end
            BUS_SLV_WAIT: begin
                // Master withdrawing the strobe aborts the access silently.
                if (!req_c) begin
                    cnt_nxt   = '0;
                    state_nxt = BUS_SLV_IDLE;
                end else if (cnt == WAIT_CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = BUS_SLV_ACK;
                end else begin
                    cnt_nxt = cnt - WAIT_CNT_W'(1);
                end
            end
            BUS_SLV_ACK: begin
                rd_ack_c    = (rw_q == READ);
                wr_commit_c = (rw_q == WRITE);
                state_nxt   = BUS_SLV_IDLE;
            end
            default: begin
                state_nxt = BUS_SLV_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bus_slave_regfile.sv
// Register-mapped slave: REG_NUM x 32-bit registers reachable from the slave
// bus (with wait states) and writable directly by the owning peripheral.
module bus_slave_regfile
    import bus_slave_regfile_pkg::*;
#(
    parameter int unsigned REG_NUM     = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         s_cs_,
    input  logic                         s_as_,
    input  logic                         s_rw,
    input  logic [WORD_ADDR_W-1:0]       s_addr,
    input  logic [WORD_DATA_W-1:0]       s_wr_data,
    output logic [WORD_DATA_W-1:0]       s_rd_data,
    output logic                         s_rdy_,
    input  logic                         hw_we_,
    input  logic [IDX_W-1:0]             hw_idx,
    input  logic [WORD_DATA_W-1:0]       hw_wr_data,
    output logic [REG_NUM*WORD_DATA_W-1:0] reg_q
);

    logic                   req_c;
    logic                   latch_c;
    logic                   rd_ack_c;
    logic                   wr_commit_c;
    logic [IDX_W-1:0]       idx_q;
    logic [WORD_DATA_W-1:0] wr_data_q;
    logic [WORD_DATA_W-1:0] regs [REG_NUM];
    logic                   unused_addr_hi;

    assign req_c = (s_cs_ == ENABLE_) && (s_as_ == ENABLE_);

    // Upper address bits belong to the decoder.
    assign unused_addr_hi = ^s_addr[WORD_ADDR_W-1:IDX_W];

    bus_slave_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk         (clk),
        .reset_      (reset_),
        .req_c       (req_c),
        .rw          (s_rw),
        .rdy_        (s_rdy_),
        .latch_c     (latch_c),
        .rd_ack_c    (rd_ack_c),
        .wr_commit_c (wr_commit_c)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            idx_q     <= '0;
            wr_data_q <= '0;
        end else if (latch_c) begin
            idx_q     <= s_addr[IDX_W-1:0];
            wr_data_q <= s_wr_data;
        end
    end

    // Bus commit is ordered after the peripheral write so it wins a same-index collision.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (hw_we_ == ENABLE_) begin
                regs[hw_idx] <= hw_wr_data;
            end
            if (wr_commit_c) begin
                regs[idx_q] <= wr_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s_rd_data <= '0;
        end else begin
            s_rd_data <= rd_ack_c ? regs[idx_q] : '0;
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
        assign reg_q[WORD_DATA_W*g +: WORD_DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Directed bench for bus_slave_regfile: one zero-wait and one three-wait
// instance share stimulus; each step checks the instance it targets.
module tb_bus_slave_regfile;
    import bus_slave_regfile_pkg::*;

    localparam int unsigned REG_NUM = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned QW      = REG_NUM * 32;

    logic                   clk = 1'b0;
    logic                   reset_;
    logic                   s_cs_, s_as_, s_rw;
    logic [WORD_ADDR_W-1:0] s_addr;
    logic [WORD_DATA_W-1:0] s_wr_data;
    logic                   hw_we_;
    logic [IDX_W-1:0]       hw_idx;
    logic [WORD_DATA_W-1:0] hw_wr_data;

    logic [WORD_DATA_W-1:0] rd0, rd3, rd_s;
    logic                   rdy0_, rdy3_, rdy_s;
    logic [QW-1:0]          q0, q3, q_s;
    logic                   sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_slave_regfile #(.REG_NUM(REG_NUM), .IDX_W(IDX_W), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset_(reset_), .s_cs_(s_cs_), .s_as_(s_as_), .s_rw(s_rw),
        .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rd_data(rd0), .s_rdy_(rdy0_),
        .hw_we_(hw_we_), .hw_idx(hw_idx), .hw_wr_data(hw_wr_data), .reg_q(q0)
    );

    bus_slave_regfile #(.REG_NUM(REG_NUM), .IDX_W(IDX_W), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset_(reset_), .s_cs_(s_cs_), .s_as_(s_as_), .s_rw(s_rw),
        .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rd_data(rd3), .s_rdy_(rdy3_),
        .hw_we_(hw_we_), .hw_idx(hw_idx), .hw_wr_data(hw_wr_data), .reg_q(q3)
    );

    assign rdy_s = sel ? rdy3_ : rdy0_;
    assign rd_s  = sel ? rd3   : rd0;
    assign q_s   = sel ? q3    : q0;

    task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_set(input logic rw, input logic [WORD_ADDR_W-1:0] addr,
                           input logic [WORD_DATA_W-1:0] data);
        s_cs_     = 1'b0;
        s_as_     = 1'b0;
        s_rw      = rw;
        s_addr    = addr;
        s_wr_data = data;
    endtask

    task automatic bus_clr();
        s_cs_ = 1'b1;
        s_as_ = 1'b1;
    endtask

    task automatic hw_write(input logic [IDX_W-1:0] idx, input logic [WORD_DATA_W-1:0] data);
        hw_we_     = 1'b0;
        hw_idx     = idx;
        hw_wr_data = data;
        tick();
        hw_we_     = 1'b1;
    endtask

    task automatic idle(input int n);
        bus_clr();
        repeat (n) tick();
    endtask

    // Reads idx 0..3 with the strobe held low; expects one pulse per w+2 cycles.
    task automatic b2b(input int w);
        s_cs_ = 1'b0;
        s_as_ = 1'b0;
        s_rw  = READ;
        for (int i = 0; i < 4; i++) begin
            s_addr = WORD_ADDR_W'(i);
            tick();
            check($sformatf("b2b_w%0d_gap_rdy_%0d", w, i), rdy_s, 1'b1);
            check($sformatf("b2b_w%0d_gap_rd_%0d", w, i), rd_s, '0);
            for (int c = 0; c < w; c++) begin
                tick();
                check($sformatf("b2b_w%0d_wait_rdy_%0d_%0d", w, i, c), rdy_s, 1'b1);
                check($sformatf("b2b_w%0d_wait_rd_%0d_%0d", w, i, c), rd_s, '0);
            end
            tick();
            check($sformatf("b2b_w%0d_pulse_%0d", w, i), rdy_s, 1'b0);
            check($sformatf("b2b_w%0d_data_%0d", w, i), rd_s, 32'h600D_0000 + 32'(i));
        end
        bus_clr();
        tick();
        check($sformatf("b2b_w%0d_end_rdy", w), rdy_s, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_     = 1'b0;
        sel        = 1'b0;
        s_cs_      = 1'b1;
        s_as_      = 1'b1;
        s_rw       = READ;
        s_addr     = '0;
        s_wr_data  = '0;
        hw_we_     = 1'b1;
        hw_idx     = '0;
        hw_wr_data = '0;

        #12;
        check("rst_rdy0", rdy0_, 1'b1);
        check("rst_rdy3", rdy3_, 1'b1);
        check("rst_rd0", rd0, '0);
        check("rst_q0", q0, '0);
        check("rst_q3", q3, '0);
        reset_ = 1'b1;
        tick();

        // Zero-wait write then read of idx 2.
        sel = 1'b0;
        bus_set(WRITE, 30'd2, 32'hDEAD_BEEF);
        tick();
        bus_clr();
        check("t1_wr_pre_rdy", rdy_s, 1'b1);
        tick();
        check("t1_wr_rdy", rdy_s, 1'b0);
        check("t1_wr_rd_zero", rd_s, '0);
        check("t1_wr_reg2", q_s[95:64], 32'hDEAD_BEEF);
        tick();
        check("t1_wr_post_rdy", rdy_s, 1'b1);
        bus_set(READ, 30'd2, 32'h0);
        tick();
        bus_clr();
        tick();
        check("t1_rd_rdy", rdy_s, 1'b0);
        check("t1_rd_data", rd_s, 32'hDEAD_BEEF);
        tick();
        check("t1_rd_post_rdy", rdy_s, 1'b1);
        check("t1_rd_post_data", rd_s, '0);

        // Three-wait read of idx 5: pulse four cycles after the request edge.
        sel = 1'b1;
        hw_write(3'd5, 32'hCAFE_0005);
        bus_set(READ, 30'd5, 32'h0);
        tick();
        check("t2_rdy_e0", rdy_s, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("t2_rdy_e%0d", c), rdy_s, 1'b1);
        end
        tick();
        bus_clr();
        check("t2_rdy_e4", rdy_s, 1'b0);
        check("t2_data", rd_s, 32'hCAFE_0005);
        tick();
        check("t2_rdy_e5", rdy_s, 1'b1);
        check("t2_data_e5", rd_s, '0);
        idle(2);

        // Abort: strobe withdrawn during wait states.
        bus_set(WRITE, 30'd1, 32'h0000_1234);
        tick();
        bus_clr();
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("t3_no_rdy_%0d", c), rdy_s, 1'b1);
        end
        check("t3_reg1", q_s[63:32], '0);

        // Collision: bus write and peripheral write on the same commit edge.
        sel = 1'b0;
        idle(2);
        bus_set(WRITE, 30'd3, 32'h0000_AAAA);
        tick();
        bus_clr();
        hw_we_ = 1'b0; hw_idx = 3'd3; hw_wr_data = 32'h0000_5555;
        tick();
        hw_we_ = 1'b1;
        check("t4_same_rdy", rdy_s, 1'b0);
        check("t4_same_reg3", q_s[127:96], 32'h0000_AAAA);
        idle(4);
        bus_set(WRITE, 30'd3, 32'h0000_BBBB);
        tick();
        bus_clr();
        hw_we_ = 1'b0; hw_idx = 3'd4; hw_wr_data = 32'h0000_5555;
        tick();
        hw_we_ = 1'b1;
        check("t4_diff_reg3", q_s[127:96], 32'h0000_BBBB);
        check("t4_diff_reg4", q_s[159:128], 32'h0000_5555);
        idle(4);

        // Asynchronous reset in the middle of a waited read.
        sel = 1'b1;
        hw_write(3'd7, 32'h7777_0007);
        check("t5_hw_reg7", q_s[255:224], 32'h7777_0007);
        bus_set(READ, 30'd7, 32'h0);
        tick();
        tick();
        check("t5_pre_rdy", rdy_s, 1'b1);
        #3;
        reset_ = 1'b0;
        #1;
        check("t5_rst_rdy3", rdy3_, 1'b1);
        check("t5_rst_rd3", rd3, '0);
        check("t5_rst_q3", q3, '0);
        check("t5_rst_rdy0", rdy0_, 1'b1);
        check("t5_rst_q0", q0, '0);
        bus_clr();
        #2;
        reset_ = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t5_idle_rdy_%0d", c), rdy_s, 1'b1);
        end
        bus_set(READ, 30'd7, 32'h0);
        repeat (4) tick();
        bus_clr();
        check("t5_after_rdy_early", rdy_s, 1'b1);
        tick();
        check("t5_after_rdy", rdy_s, 1'b0);
        check("t5_after_data", rd_s, '0);
        idle(3);

        // Back-to-back reads on both instances.
        for (int i = 0; i < 4; i++) begin
            hw_write(IDX_W'(i), 32'h600D_0000 + 32'(i));
        end
        sel = 1'b1;
        idle(2);
        b2b(3);
        sel = 1'b0;
        idle(4);
        b2b(0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
